// File: rtl/shift_left_logical_seq.sv
// Iterative logical left shifter with valid/ready handshakes on both sides.
// The shift is done in steps of 4 or 1 bit per cycle. Zero fill, no rotate.
module shift_left_logical_seq #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [N-1:0]  data_reg, data_next;
  logic [SW-1:0] rem_reg, rem_next;
  logic [N-1:0]  out_data_reg, out_data_next;

  // Handshake flags and busy are decoded from the state register only.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;

  // State, working data, remaining count and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      rem_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      rem_reg      <= rem_next;
      out_data_reg <= out_data_next;
    end
  end

  // Next-state logic: accept in IDLE, step the shift in SHIFT, hold in DONE.
  // The result register is loaded on entry to DONE and cleared on exit, so
  // out_data reads zero whenever no result is being offered.
  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    rem_next      = rem_reg;
    out_data_next = out_data_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          data_next = in_data;
          rem_next  = in_shamt;
          if (in_shamt == '0) begin
            state_next    = DONE;
            out_data_next = in_data;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Coarse steps of 4 first, then single-bit steps for the remainder.
        if (rem_reg >= SW'(4)) begin
          data_next = data_reg << 4;
          rem_next  = rem_reg - SW'(4);
        end else begin
          data_next = data_reg << 1;
          rem_next  = rem_reg - SW'(1);
        end
        if (rem_next == '0) begin
          state_next    = DONE;
          out_data_next = data_next;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next    = IDLE;
          out_data_next = '0;
        end
      end
      default: begin
        state_next    = IDLE;
        out_data_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_left_logical_seq.sv
// Bench for shift_left_logical_seq: directed cases with literal expectations,
// then a randomized sweep, all compared every cycle against a behavioural model.
module tb_shift_left_logical_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  shift_left_logical_seq #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: an accepted operand yields in_data << s after
  // k = s/4 + s%4 cycles of work, then waits for out_ready.
  // phase: 0 = waiting for operand, 1 = working, 2 = offering result.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   = in_data << in_shamt;
          m_cnt   = int'(in_shamt) / 4 + int'(in_shamt) % 4;
          m_phase = (m_cnt == 0) ? 2 : 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      chk("model out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      chk("model busy", {31'd0, busy}, {31'd0, m_phase != 0});
      chk("model out_data", out_data, (m_phase == 2) ? m_res : 32'd0);
    end
  end

  // One directed operation with literal result and latency expectations.
  task automatic op(input logic [31:0] d, input logic [4:0] s, input int hold,
                    input logic [31:0] exp_d, input int exp_k, input string nm);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_shamt = s; out_ready = (hold == 0);
    @(posedge clk); #1;  // acceptance edge E0 has passed
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, exp_k);
    chk({nm, " out_data"}, out_data, exp_d);
    chk({nm, " busy in done"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      @(negedge clk);
      chk({nm, " held valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, " held data"}, out_data, exp_d);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " back idle"}, {31'd0, in_ready}, 32'd1);
    chk({nm, " valid dropped"}, {31'd0, out_valid}, 32'd0);
    chk({nm, " data cleared"}, out_data, 32'd0);
    $display("op %s: data=%h s=%0d -> out=%h latency=%0d", nm, d, s, exp_d, lat);
  endtask

  initial begin
    int guard;
    logic [31:0] d;
    logic [4:0]  s;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(32'hDEADBEEF, 5'd0, 0, 32'hDEADBEEF, 0, "s0");
    op(32'h00000001, 5'd5, 0, 32'h00000020, 2, "s5");
    op(32'hFFFFFFFF, 5'd31, 0, 32'h80000000, 10, "s31");
    op(32'h12345678, 5'd8, 5, 32'h34567800, 2, "backpressure");

    // Reset during the third SHIFT cycle of an s=20 operation.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_shamt = 5'd20; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("after reset no valid", {31'd0, out_valid}, 32'd0);
    end
    $display("op midreset: s=20 operation aborted by reset");
    op(32'h00000001, 5'd1, 0, 32'h00000002, 1, "after reset");

    // Randomized sweep; the per-cycle model compare does the checking.
    for (int n = 0; n < 1000; n++) begin
      guard = 0;
      while (!in_ready && guard < 100) begin
        in_valid  = ($urandom % 4 == 0);
        in_data   = $urandom;
        in_shamt  = 5'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) begin
        errors++;
        $display("FAIL sweep timeout: in_ready stuck at %0d, required 1", in_ready);
        break;
      end
      d = $urandom;
      s = 5'($urandom);
      in_valid = 1'b1; in_data = d; in_shamt = s; out_ready = 1'($urandom);
      @(posedge clk); #1;
      $display("sweep %0d: data=%h s=%0d expect=%h", n, d, s, d << s);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
